// File: rtl/noc_pkg.sv
// Shared mesh constants and the TX injection FSM encoding for the network interface.
package noc_pkg;

  localparam int unsigned NUM_of_NODES          = 16;
  localparam int unsigned NUM_of_LINES          = 4;
  localparam int unsigned NUM_of_NODES_per_LINE = 4;
  localparam int unsigned ADDRESS_WIDTH         = 5;
  localparam int unsigned DATA_WIDTH            = 32;
  localparam int unsigned NODE_ID_BITS          = 4;

  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_SEND = 1'b1;

  typedef enum logic {
    StIdle = STATE_IDLE,
    StSend = STATE_SEND
  } tx_state_e;

endpackage

// File: rtl/noc_sync_fifo.sv
// Synchronous FIFO exposing the head entry and the entry behind it for back-to-back reads.
module noc_sync_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic [WIDTH-1:0]           o_head,
  output logic [WIDTH-1:0]           o_next
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_next  = r_mem[r_rd_ptr + PW'(1)];

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (PW+1)'(1);
      else if (!w_push && w_pop) r_count <= r_count - (PW+1)'(1);
    end
  end

endmodule

// File: rtl/noc_net_if.sv
// Mesh node network interface: buffered TX injection plus destination-checked RX ejection.
// Optional macro NOC_NET_IF_STATS_EN adds saturating 16-bit traffic counters.
module noc_net_if
  import noc_pkg::*;
#(
  parameter int unsigned NODE_ID       = 0,
  parameter int unsigned ADDRESS_WIDTH = noc_pkg::ADDRESS_WIDTH,
  parameter int unsigned DATA_WIDTH    = noc_pkg::DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [ADDRESS_WIDTH-1:0] i_tx_addr,
  input  logic [DATA_WIDTH-1:0]    i_tx_data,
  input  logic                     i_tx_valid,
  output logic                     o_tx_ready,
  output logic [ADDRESS_WIDTH-1:0] o_ni_addr,
  output logic [DATA_WIDTH-1:0]    o_ni_data,
  output logic                     o_ni_valid,
  input  logic                     i_ni_ack,
  input  logic [ADDRESS_WIDTH-1:0] i_node_addr,
  input  logic [DATA_WIDTH-1:0]    i_node_data,
  input  logic                     i_node_valid,
  output logic                     o_node_ack,
  output logic [ADDRESS_WIDTH-1:0] o_rx_addr,
  output logic [DATA_WIDTH-1:0]    o_rx_data,
  output logic                     o_rx_valid,
  input  logic                     i_rx_ready,
`ifdef NOC_NET_IF_STATS_EN
  output logic [15:0]              o_tx_count,
  output logic [15:0]              o_rx_count,
  output logic [15:0]              o_misroute_count,
`endif
  output logic                     o_err_misroute,
  output logic                     o_err_self
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned FW = ADDRESS_WIDTH + DATA_WIDTH;
  localparam logic [NODE_ID_BITS-1:0] LP_ID = NODE_ID_BITS'(NODE_ID);

  tx_state_e               r_state;
  tx_state_e               w_state_next;
  logic                    w_full;
  logic                    w_empty;
  logic [PW:0]             w_count;
  logic [FW-1:0]           w_head;
  logic [FW-1:0]           w_next;
  logic                    w_push_req;
  logic                    w_self;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_load;
  logic                    w_load_next;
  logic                    w_clear;
  logic [FW-1:0]           w_load_flit;
  logic                    r_ni_valid;
  logic [ADDRESS_WIDTH-1:0] r_ni_addr;
  logic [DATA_WIDTH-1:0]   r_ni_data;
  logic                    r_err_self;
  logic                    r_err_misroute;
  logic                    r_rx_valid;
  logic [ADDRESS_WIDTH-1:0] r_rx_addr;
  logic [DATA_WIDTH-1:0]   r_rx_data;
  logic                    w_rx_xfer;
  logic                    w_rx_match;
  logic                    w_rx_capture;

  assign o_tx_ready = !w_full;
  assign w_push_req = i_tx_valid && o_tx_ready;
  assign w_self     = (i_tx_addr[NODE_ID_BITS-1:0] == LP_ID);
  assign w_push     = w_push_req && !w_self;

  noc_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_wdata ({i_tx_addr, i_tx_data}),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_head  (w_head),
    .o_next  (w_next)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (!w_empty) w_state_next = StSend;
      StSend: if (i_ni_ack && (w_count < (PW+1)'(2))) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // The flit on ni_* stays at the FIFO head until acked, so a follow-on flit is head+1.
  always_comb begin
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_load_next = 1'b0;
    w_clear     = 1'b0;
    unique case (r_state)
      StIdle: w_load = !w_empty;
      StSend: begin
        if (i_ni_ack) begin
          w_pop = 1'b1;
          if (w_count >= (PW+1)'(2)) begin
            w_load      = 1'b1;
            w_load_next = 1'b1;
          end else begin
            w_clear = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign w_load_flit = w_load_next ? w_next : w_head;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ni_valid <= 1'b0;
      r_ni_addr  <= '0;
      r_ni_data  <= '0;
      r_err_self <= 1'b0;
    end else begin
      r_err_self <= w_push_req && w_self;
      if (w_load) begin
        r_ni_valid <= 1'b1;
        r_ni_addr  <= w_load_flit[FW-1:DATA_WIDTH];
        r_ni_data  <= w_load_flit[DATA_WIDTH-1:0];
      end else if (w_clear) begin
        r_ni_valid <= 1'b0;
      end
    end
  end

  assign o_ni_valid = r_ni_valid;
  assign o_ni_addr  = r_ni_addr;
  assign o_ni_data  = r_ni_data;
  assign o_err_self = r_err_self;

  assign o_node_ack   = !r_rx_valid || i_rx_ready;
  assign w_rx_xfer    = i_node_valid && o_node_ack;
  assign w_rx_match   = (i_node_addr[NODE_ID_BITS-1:0] == LP_ID);
  assign w_rx_capture = w_rx_xfer && w_rx_match;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_valid     <= 1'b0;
      r_rx_addr      <= '0;
      r_rx_data      <= '0;
      r_err_misroute <= 1'b0;
    end else begin
      r_err_misroute <= w_rx_xfer && !w_rx_match;
      if (w_rx_capture) begin
        r_rx_valid <= 1'b1;
        r_rx_addr  <= i_node_addr;
        r_rx_data  <= i_node_data;
      end else if (r_rx_valid && i_rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign o_rx_valid     = r_rx_valid;
  assign o_rx_addr      = r_rx_addr;
  assign o_rx_data      = r_rx_data;
  assign o_err_misroute = r_err_misroute;

`ifdef NOC_NET_IF_STATS_EN
  logic [15:0] r_tx_count;
  logic [15:0] r_rx_count;
  logic [15:0] r_misroute_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx_count       <= '0;
      r_rx_count       <= '0;
      r_misroute_count <= '0;
    end else begin
      if (r_ni_valid && i_ni_ack && (r_tx_count != 16'hFFFF)) r_tx_count <= r_tx_count + 16'd1;
      if (w_rx_capture && (r_rx_count != 16'hFFFF))          r_rx_count <= r_rx_count + 16'd1;
      if (w_rx_xfer && !w_rx_match && (r_misroute_count != 16'hFFFF)) begin
        r_misroute_count <= r_misroute_count + 16'd1;
      end
    end
  end

  assign o_tx_count       = r_tx_count;
  assign o_rx_count       = r_rx_count;
  assign o_misroute_count = r_misroute_count;
`endif

endmodule

// File: tb/tb_noc_net_if.sv
// Scoreboard bench for noc_net_if: directed scenarios then randomized traffic in both directions.
module tb_noc_net_if;

  localparam int unsigned ID    = 5;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic [AW-1:0] i_tx_addr = '0;
  logic [DW-1:0] i_tx_data = '0;
  logic          i_tx_valid = 1'b0;
  logic          o_tx_ready;
  logic [AW-1:0] o_ni_addr;
  logic [DW-1:0] o_ni_data;
  logic          o_ni_valid;
  logic          i_ni_ack = 1'b1;
  logic [AW-1:0] i_node_addr = '0;
  logic [DW-1:0] i_node_data = '0;
  logic          i_node_valid = 1'b0;
  logic          o_node_ack;
  logic [AW-1:0] o_rx_addr;
  logic [DW-1:0] o_rx_data;
  logic          o_rx_valid;
  logic          i_rx_ready = 1'b1;
  logic          o_err_misroute;
  logic          o_err_self;
`ifdef NOC_NET_IF_STATS_EN
  logic [15:0]   o_tx_count;
  logic [15:0]   o_rx_count;
  logic [15:0]   o_misroute_count;
`endif

  noc_net_if #(
    .NODE_ID       (ID),
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_tx_addr        (i_tx_addr),
    .i_tx_data        (i_tx_data),
    .i_tx_valid       (i_tx_valid),
    .o_tx_ready       (o_tx_ready),
    .o_ni_addr        (o_ni_addr),
    .o_ni_data        (o_ni_data),
    .o_ni_valid       (o_ni_valid),
    .i_ni_ack         (i_ni_ack),
    .i_node_addr      (i_node_addr),
    .i_node_data      (i_node_data),
    .i_node_valid     (i_node_valid),
    .o_node_ack       (o_node_ack),
    .o_rx_addr        (o_rx_addr),
    .o_rx_data        (o_rx_data),
    .o_rx_valid       (o_rx_valid),
    .i_rx_ready       (i_rx_ready),
`ifdef NOC_NET_IF_STATS_EN
    .o_tx_count       (o_tx_count),
    .o_rx_count       (o_rx_count),
    .o_misroute_count (o_misroute_count),
`endif
    .o_err_misroute   (o_err_misroute),
    .o_err_self       (o_err_self)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit armed   = 1'b0;

  // Reference model: flits accepted but not yet injected, and flits delivered but not yet consumed.
  logic [AW+DW-1:0] tx_q[$];
  logic [AW+DW-1:0] rx_q[$];
  logic exp_self = 1'b0;
  logic exp_mis  = 1'b0;
  int   m_tx_cnt = 0;
  int   m_rx_cnt = 0;
  int   m_mis_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_me(input logic [AW-1:0] a);
    return a[3:0] == 4'(ID);
  endfunction

  always @(negedge i_clk) begin
    if (armed) begin
      check("err_self", 64'(o_err_self), 64'(exp_self));
      check("err_misroute", 64'(o_err_misroute), 64'(exp_mis));
      check("tx_ready", 64'(o_tx_ready), 64'(tx_q.size() < DEPTH));
      check("rx_valid", 64'(o_rx_valid), 64'(rx_q.size() != 0));
      check("node_ack", 64'(o_node_ack), 64'(rx_q.size() == 0 || i_rx_ready));
`ifdef NOC_NET_IF_STATS_EN
      check("tx_count", 64'(o_tx_count), 64'(m_tx_cnt));
      check("rx_count", 64'(o_rx_count), 64'(m_rx_cnt));
      check("misroute_count", 64'(o_misroute_count), 64'(m_mis_cnt));
`endif
      if (i_rst) begin
        tx_q.delete();
        rx_q.delete();
        exp_self  = 1'b0;
        exp_mis   = 1'b0;
        m_tx_cnt  = 0;
        m_rx_cnt  = 0;
        m_mis_cnt = 0;
      end else begin
        if (o_ni_valid) begin
          if (tx_q.size() == 0) begin
            check("ni_valid_spurious", 64'(o_ni_valid), 64'(0));
          end else begin
            check("ni_flit", 64'({o_ni_addr, o_ni_data}), 64'(tx_q[0]));
            if (i_ni_ack) begin
              void'(tx_q.pop_front());
              m_tx_cnt++;
            end
          end
        end
        if (o_rx_valid && rx_q.size() != 0) begin
          check("rx_flit", 64'({o_rx_addr, o_rx_data}), 64'(rx_q[0]));
          if (i_rx_ready) void'(rx_q.pop_front());
        end
        exp_mis = 1'b0;
        if (i_node_valid && o_node_ack) begin
          if (is_me(i_node_addr)) begin
            rx_q.push_back({i_node_addr, i_node_data});
            m_rx_cnt++;
          end else begin
            exp_mis = 1'b1;
            m_mis_cnt++;
          end
        end
        exp_self = 1'b0;
        if (i_tx_valid && o_tx_ready) begin
          if (is_me(i_tx_addr)) exp_self = 1'b1;
          else tx_q.push_back({i_tx_addr, i_tx_data});
        end
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  logic [AW-1:0] t2_addr [5];
  bit tx_x;
  bit rx_x;

  initial begin
    t2_addr[0] = 5'd1; t2_addr[1] = 5'd2; t2_addr[2] = 5'd3; t2_addr[3] = 5'd4; t2_addr[4] = 5'd6;
    i_rst = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
    armed = 1'b1;
    check("rst_ni_valid", 64'(o_ni_valid), 64'(0));
    check("rst_ni_addr", 64'(o_ni_addr), 64'(0));
    check("rst_ni_data", 64'(o_ni_data), 64'(0));
    check("rst_rx_addr", 64'(o_rx_addr), 64'(0));
    check("rst_rx_data", 64'(o_rx_data), 64'(0));
    check("rst_tx_ready", 64'(o_tx_ready), 64'(1));
    check("rst_node_ack", 64'(o_node_ack), 64'(1));

    // Single send latency
    i_ni_ack = 1'b1;
    i_tx_addr = 5'd4; i_tx_data = 32'h4; i_tx_valid = 1'b1;
    tick();
    i_tx_valid = 1'b0;
    check("t1_ni_valid_e1", 64'(o_ni_valid), 64'(0));
    tick();
    check("t1_ni_valid_e2", 64'(o_ni_valid), 64'(1));
    check("t1_ni_addr_e2", 64'(o_ni_addr), 64'(4));
    tick();
    check("t1_ni_valid_e3", 64'(o_ni_valid), 64'(0));
    check("t1_tx_ready", 64'(o_tx_ready), 64'(1));

    // Backpressure into a full FIFO
    i_ni_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      i_tx_addr = t2_addr[i]; i_tx_data = 32'(100 + i); i_tx_valid = 1'b1;
      tick();
    end
    i_tx_valid = 1'b0;
    check("t2_full_ready", 64'(o_tx_ready), 64'(0));
    check("t2_held_valid", 64'(o_ni_valid), 64'(1));
    i_ni_ack = 1'b1;
    tick();
    check("t2_ready_after_pop", 64'(o_tx_ready), 64'(1));
    check("t2_b2b_1", 64'(o_ni_valid), 64'(1));
    tick();
    check("t2_b2b_2", 64'(o_ni_valid), 64'(1));
    tick();
    check("t2_b2b_3", 64'(o_ni_valid), 64'(1));
    tick();
    check("t2_drained", 64'(o_ni_valid), 64'(0));

    // Self-addressed flit is dropped
    i_tx_addr = 5'(ID); i_tx_data = 32'hABCD; i_tx_valid = 1'b1;
    tick();
    i_tx_valid = 1'b0;
    check("t3_err_self_hi", 64'(o_err_self), 64'(1));
    tick();
    check("t3_err_self_lo", 64'(o_err_self), 64'(0));
    check("t3_no_send", 64'(o_ni_valid), 64'(0));

    // RX delivery with host stall
    i_rx_ready = 1'b0;
    i_node_addr = 5'(ID); i_node_data = 32'hDEADBEEF; i_node_valid = 1'b1;
    tick();
    i_node_data = 32'h12345678;
    check("t4_rx_valid", 64'(o_rx_valid), 64'(1));
    check("t4_rx_data", 64'(o_rx_data), 64'hDEADBEEF);
    check("t4_stall_ack", 64'(o_node_ack), 64'(0));
    tick();
    check("t4_rx_hold", 64'(o_rx_data), 64'hDEADBEEF);
    i_rx_ready = 1'b1;
    #1;
    check("t4_ack_release", 64'(o_node_ack), 64'(1));
    tick();
    i_node_valid = 1'b0;
    check("t4_second_valid", 64'(o_rx_valid), 64'(1));
    check("t4_second_data", 64'(o_rx_data), 64'h12345678);
    tick();
    check("t4_consumed", 64'(o_rx_valid), 64'(0));

    // Misrouted ejection
    i_node_addr = 5'd3; i_node_data = 32'h3333; i_node_valid = 1'b1;
    #1;
    check("t5_ack", 64'(o_node_ack), 64'(1));
    tick();
    i_node_valid = 1'b0;
    check("t5_mis_hi", 64'(o_err_misroute), 64'(1));
    check("t5_rx_idle", 64'(o_rx_valid), 64'(0));
    tick();
    check("t5_mis_lo", 64'(o_err_misroute), 64'(0));

    // Reset while a send is stalled
    i_ni_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_tx_addr = 5'(i + 8); i_tx_data = 32'(200 + i); i_tx_valid = 1'b1;
      tick();
    end
    i_tx_valid = 1'b0;
    tick();
    check("t6_sending", 64'(o_ni_valid), 64'(1));
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check("t6_ni_valid", 64'(o_ni_valid), 64'(0));
    check("t6_tx_ready", 64'(o_tx_ready), 64'(1));
`ifdef NOC_NET_IF_STATS_EN
    check("t6_tx_count", 64'(o_tx_count), 64'(0));
    check("t6_rx_count", 64'(o_rx_count), 64'(0));
    check("t6_mis_count", 64'(o_misroute_count), 64'(0));
`endif
    i_ni_ack = 1'b1;
    tick();
    tick();
    check("t6_flushed", 64'(o_ni_valid), 64'(0));

    // Randomized traffic; senders hold flits until transferred
    tx_x = 1'b1;
    rx_x = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (!i_tx_valid || tx_x) begin
        i_tx_valid = ($urandom % 3) != 0;
        i_tx_addr  = ($urandom % 7 == 0) ? 5'({1'($urandom), 4'(ID)}) : 5'($urandom);
        i_tx_data  = $urandom;
      end
      if (!i_node_valid || rx_x) begin
        i_node_valid = ($urandom % 2) != 0;
        i_node_addr  = ($urandom % 4 == 0) ? 5'($urandom) : 5'({1'($urandom), 4'(ID)});
        i_node_data  = $urandom;
      end
      i_ni_ack   = ($urandom % 4) != 0;
      i_rx_ready = ($urandom % 3) != 0;
      @(negedge i_clk);
      tx_x = i_tx_valid && o_tx_ready;
      rx_x = i_node_valid && o_node_ack;
      tick();
    end

    i_tx_valid   = 1'b0;
    i_node_valid = 1'b0;
    i_ni_ack     = 1'b1;
    i_rx_ready   = 1'b1;
    for (int c = 0; c < 20; c++) tick();
    check("drain_tx", 64'(tx_q.size()), 64'(0));
    check("drain_rx", 64'(rx_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/noc_net_if.md
Name: noc_net_if

Overview:
- Network interface between a local host/PE and the local port of one mesh router node (32-bit data, 5-bit address).
- TX path: buffers host flits in a small FIFO and injects them into the node's input port using the valid/ack handshake.
- RX path: accepts flits ejected on the node's output port, checks that the destination matches this node, and hands them to the host.
- One instance per mesh node, placed directly upstream (inject) and downstream (eject) of the node's local port.

Parameters:
- NODE_ID, 0, mesh ID of the attached node (0..15; line*4 + position).
- ADDRESS_WIDTH, 5, flit address width; bits [3:0] hold the destination node ID, bit [4] is reserved and passed through.
- DATA_WIDTH, 32, flit payload width.
- FIFO_DEPTH, 4, TX FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset.
- tx_addr  in  ADDRESS_WIDTH  host flit destination.
- tx_data  in  DATA_WIDTH  host flit payload.
- tx_valid  in  1  host offers a flit.
- tx_ready  out  1  TX FIFO can accept.
- ni_addr  out  ADDRESS_WIDTH  to node in_addr (local port).
- ni_data  out  DATA_WIDTH  to node in_data.
- ni_valid  out  1  to node in_valid.
- ni_ack  in  1  from node to_in_ack.
- node_addr  in  ADDRESS_WIDTH  from node out_addr.
- node_data  in  DATA_WIDTH  from node out_data.
- node_valid  in  1  from node out_valid.
- node_ack  out  1  to node from_out_ack.
- rx_addr  out  ADDRESS_WIDTH  delivered flit address.
- rx_data  out  DATA_WIDTH  delivered payload.
- rx_valid  out  1  delivered flit available.
- rx_ready  in  1  host consumes.
- err_misroute  out  1  one-cycle pulse: an ejected flit was not addressed to NODE_ID.
- err_self  out  1  one-cycle pulse: host flit addressed to NODE_ID was dropped.

Behaviour:
- Clocking and reset: single clock clk. Reset rst is synchronous, active-high.
- Reset values:
  - TX FIFO is empty and the FSM is in IDLE.
  - ni_valid=0; ni_addr and ni_data are 0.
  - rx_valid=0; rx_addr and rx_data are 0.
  - err_misroute=0, err_self=0.
  - tx_ready=1 and node_ack=1 in the first cycle after reset.
- Reset mid-operation:
  - The FIFO is flushed and any held injection is abandoned.
  - ni_valid is 0 in the cycle after the reset edge.
  - A flit being injected at that time is lost. This is accepted behaviour.
- Handshake, both directions:
  - A transfer occurs on a rising edge where valid=1 and ack (or ready)=1.
  - The sender holds addr/data stable while valid=1 and no transfer has occurred.
- TX push:
  - tx_ready = !full (combinational from the occupancy count).
  - A push occurs when tx_valid && tx_ready.
  - If tx_addr[3:0]==NODE_ID, the flit is not written; instead err_self pulses in the next cycle.
- TX pop while full: a simultaneous pop does not enable a push in that same cycle.
- TX FSM: two states, IDLE and SEND.
  - IDLE, FIFO not empty: load the head into the ni_* registers, set ni_valid=1, go to SEND.
  - SEND, ni_ack=0: hold outputs unchanged.
  - SEND, ni_ack=1: pop the FIFO. If another entry remains, load it in the same edge and stay in SEND (back-to-back, one flit per cycle). Otherwise clear ni_valid and go to IDLE.
- TX latency: a push into an empty FIFO at edge N gives ni_valid=1 after edge N+1.
- FIFO pointers: log2(FIFO_DEPTH) bits, natural wrap. Occupancy counter is log2(FIFO_DEPTH)+1 bits.
- RX:
  - Single-entry output register. node_ack = !rx_valid || rx_ready (combinational).
  - On a transfer with node_addr[3:0]==NODE_ID: capture addr and data, set rx_valid=1.
  - On a transfer with node_addr[3:0]!=NODE_ID: the flit is acked and discarded, err_misroute pulses the next cycle, and rx state is unchanged.
  - rx_valid && rx_ready clears rx_valid unless a new capture happens on the same edge; in that case the new flit is loaded and rx_valid stays 1.
- TX and RX paths are fully independent and may transfer in the same cycle.

Optional Feature:
- Macro: NOC_NET_IF_STATS_EN.
- When defined, adds three 16-bit output ports:
  - tx_count: increments on each ni transfer.
  - rx_count: increments on each accepted RX capture.
  - misroute_count: increments with each err_misroute pulse.
- All three reset to 0, saturate at 0xFFFF, and do not wrap.
- When undefined, these ports and their logic are absent. All other behaviour is identical.

Decomposition:
- Shared package noc_pkg holds:
  - NUM_of_NODES=16, NUM_of_LINES=4, NUM_of_NODES_per_LINE=4.
  - ADDRESS_WIDTH=5, DATA_WIDTH=32.
  - NODE_ID_BITS=4.
  - Localparams for the FSM state encoding (IDLE=0, SEND=1).
- One sub-module: noc_sync_fifo, a parameterised synchronous FIFO with push, pop, full, empty, count and head data.
- The FSM and RX logic stay in noc_net_if.

Test Plan:
1. Idle to single send: with NODE_ID=0, push addr=4, data=0x4 at edge 1, ni_ack held 1 → ni_valid=1 with ni_addr=4 after edge 2, then ni_valid=0 after edge 3; tx_ready stays 1.
2. Backpressure and full FIFO: ni_ack=0; push 5 flits, addr=1..5 → first 4 accepted, then tx_ready=0; release ni_ack → 4 flits leave back-to-back in order 1,2,3,4; tx_ready returns to 1 after the first pop.
3. Self-address: NODE_ID=5, push addr=5 → no ni_valid, err_self=1 for exactly one cycle, FIFO count stays 0.
4. RX delivery and stall: node_valid=1, node_addr=0, data=0xDEADBEEF, rx_ready=0 → rx_valid=1 holding that data; node_ack=0 while held; assert rx_ready → node_ack=1, and a second flit 0x12345678 is captured on the same edge as the pop, with rx_valid staying 1.
5. Misroute: NODE_ID=0, node_addr=3 → node_ack=1, err_misroute pulses one cycle, rx_valid stays 0.
6. Reset mid-send: during SEND with ni_ack=0 and 3 flits queued, assert rst for one cycle → ni_valid=0, FIFO empty, tx_ready=1; with the stats macro defined, all counters read 0.
